fir_tap_scheduler: RTL and testbench

Resource-shared sequencer for the 6-tap FIR datapath. It accepts one vector of six samples and computes Σ sample[k]·coef[k] through a single pipelined multiplier and a single accumulator, instead of six multipliers and five adders. It sits between the sample source and the downstream variance/statistics stage. All traffic uses valid/ready handshakes, and tap coefficients come from a small register file that software loads.

---
 rtl/fir_tap_scheduler_if.sv | 28 ++
 rtl/fir_tap_scheduler.sv | 145 ++++++++++++++
 tb/tb_fir_tap_scheduler.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/fir_tap_scheduler_if.sv
// Handshake, coefficient-load and result bundle for fir_tap_scheduler.
// slave = scheduler side, master = sample source / coefficient loader / result sink side.
interface fir_tap_scheduler_if #(
  parameter int DW   = 16,
  parameter int TAPS = 6,
  parameter int AW   = 2*DW+3
);
  logic                 in_valid;
  logic                 in_ready;
  logic [TAPS*DW-1:0]   in_data;
  logic                 coef_we;
  logic [2:0]           coef_addr;
  logic [DW-1:0]        coef_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [AW-1:0]        out_data;
  logic                 busy;

  modport slave (
    input  in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/fir_tap_scheduler.sv
// Shared-multiplier FIR dot product: one tap per cycle, result TAPS+MUL_LAT+1 cycles after accept, held until out_ready.
// No new vector is taken until the result handshakes. FIR_SCHED_ZERO_SKIP_EN issues only taps with nonzero coefficients.
module fir_tap_scheduler #(
  parameter int DW      = 16,
  parameter int TAPS    = 6,
  parameter int MUL_LAT = 2,
  parameter int AW      = 2*DW+3
) (
  input logic                clk,
  input logic                rst_n,
  fir_tap_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                 state, state_nxt;
  logic [TAPS*DW-1:0]     sbuf;
  logic signed [DW-1:0]   coef [TAPS];
  logic [3:0]             n_iss, r, r_nxt;
  logic [MUL_LAT-1:0]     vld_pipe;
  logic signed [2*DW-1:0] prod_pipe [MUL_LAT];
  logic signed [AW-1:0]   acc;
  logic signed [DW-1:0]   samp, cf;
  logic signed [2*DW-1:0] mul_a, mul_b, prod;
  logic                   accept, issue, retire, coef_ok, last_issue, skip_all;
  logic                   in_ready, out_valid;
  logic [2:0]             sel;

  assign coef_ok = bus.coef_we && (state == IDLE) && ({1'b0, bus.coef_addr} < 4'(TAPS));
  assign accept  = bus.in_valid && in_ready;
  assign retire  = vld_pipe[MUL_LAT-1];
  assign r_nxt   = r + {3'd0, retire};

`ifdef FIR_SCHED_ZERO_SKIP_EN
  logic [TAPS-1:0] mask, nz_acc, sel_oh;

  // A coefficient written in the accept cycle must already count in the mask.
  always_comb begin
    nz_acc = '0;
    for (int i = 0; i < TAPS; i++) begin
      nz_acc[i] = (coef_ok && bus.coef_addr == 3'(i)) ? (bus.coef_data != '0) : (coef[i] != '0);
    end
  end

  assign sel_oh = mask & (~mask + TAPS'(1));

  always_comb begin
    sel = '0;
    for (int i = TAPS-1; i >= 0; i--) begin
      if (mask[i]) sel = 3'(i);
    end
  end

  assign last_issue = (mask & ~sel_oh) == '0;
  assign skip_all   = (nz_acc == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      mask <= '0;
    else if (accept) mask <= nz_acc;
    else if (issue)  mask <= mask & ~sel_oh;
  end
`else
  logic [2:0] k;

  assign sel        = k;
  assign last_issue = (k == 3'(TAPS-1));
  assign skip_all   = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      k <= '0;
    else if (accept) k <= '0;
    else if (issue)  k <= k + 3'd1;
  end
`endif

  always_comb begin
    samp  = sbuf[sel*DW +: DW];
    cf    = coef[sel];
    mul_a = {{DW{samp[DW-1]}}, samp};
    mul_b = {{DW{cf[DW-1]}}, cf};
    prod  = mul_a * mul_b;
  end

  // DRAIN counts the retire landing this cycle so DONE follows the final retire edge.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nxt = skip_all ? DONE : ISSUE;
      end
      ISSUE: begin
        issue = 1'b1;
        if (last_issue) state_nxt = DRAIN;
      end
      DRAIN: if (r_nxt == n_iss) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sbuf     <= '0;
      n_iss    <= '0;
      r        <= '0;
      acc      <= '0;
      vld_pipe <= '0;
      for (int i = 0; i < TAPS; i++)    coef[i]      <= '0;
      for (int i = 0; i < MUL_LAT; i++) prod_pipe[i] <= '0;
    end else begin
      state <= state_nxt;
      if (coef_ok) coef[bus.coef_addr] <= bus.coef_data;
      vld_pipe[0]  <= issue;
      prod_pipe[0] <= prod;
      for (int i = 1; i < MUL_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        prod_pipe[i] <= prod_pipe[i-1];
      end
      if (accept) begin
        sbuf  <= bus.in_data;
        acc   <= '0;
        n_iss <= '0;
        r     <= '0;
      end else begin
        if (issue) n_iss <= n_iss + 4'd1;
        if (retire) begin
          acc <= acc + {{(AW-2*DW){prod_pipe[MUL_LAT-1][2*DW-1]}}, prod_pipe[MUL_LAT-1]};
          r   <= r_nxt;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = acc;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_fir_tap_scheduler.sv
// Directed bench for fir_tap_scheduler; cycle n is the clock period that ends on the n-th edge after the accept edge.
module tb_fir_tap_scheduler;
  localparam int DW   = 16;
  localparam int TAPS = 6;
`ifdef FIR_SCHED_ZERO_SKIP_EN
  localparam int LAT_ZS   = 5;
  localparam int LAT_ZERO = 1;
`else
  localparam int LAT_ZS   = 9;
  localparam int LAT_ZERO = 9;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;
  int   lat;
  logic seen;

  fir_tap_scheduler_if #(.DW(DW), .TAPS(TAPS)) bus ();
  fir_tap_scheduler #(.DW(DW), .TAPS(TAPS), .MUL_LAT(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  function automatic logic [TAPS*DW-1:0] fill(input logic [DW-1:0] v);
    logic [TAPS*DW-1:0] d;
    for (int i = 0; i < TAPS; i++) d[i*DW +: DW] = v;
    return d;
  endfunction

  function automatic logic [TAPS*DW-1:0] ramp();
    logic [TAPS*DW-1:0] d;
    for (int i = 0; i < TAPS; i++) d[i*DW +: DW] = DW'(i + 1);
    return d;
  endfunction

  task automatic wr_coef(input int a, input logic [DW-1:0] d);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 3'(a);
    bus.coef_data = d;
    tick();
    bus.coef_we   = 1'b0;
  endtask

  task automatic wr_all(input logic [DW-1:0] d);
    for (int i = 0; i < TAPS; i++) wr_coef(i, d);
  endtask

  task automatic send(input logic [TAPS*DW-1:0] d);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Returns the cycle in which out_valid is first seen, or -1 after the budget.
  task automatic wait_out(input int start, output int l);
    l = -1;
    for (int n = start; n <= 40; n++) begin
      if (bus.out_valid === 1'b1) begin
        l = n;
        break;
      end
      tick();
    end
  endtask

  task automatic run(input string tag, input logic [TAPS*DW-1:0] d,
                     input logic signed [63:0] want, input int want_lat);
    int l;
    send(d);
    wait_out(1, l);
    chk({tag, "_lat"}, l, want_lat);
    chk({tag, "_data"}, $signed(bus.out_data), want);
    tick();
    chk({tag, "_clear"}, bus.out_valid, 0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", $signed(bus.out_data), 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    tick();

    // coef 1..6 x samples 1..6 = 91, busy through cycle 9, one-cycle out_valid
    for (int i = 0; i < TAPS; i++) wr_coef(i, DW'(i + 1));
    send(ramp());
    for (int n = 1; n <= 9; n++) begin
      chk("a_busy", bus.busy, 1);
      chk("a_valid", bus.out_valid, (n == 9));
      if (n < 9) tick();
    end
    chk("a_data", $signed(bus.out_data), 91);
    tick();
    chk("a_valid_drop", bus.out_valid, 0);
    chk("a_busy_drop", bus.busy, 0);
    chk("a_in_ready", bus.in_ready, 1);

    // backpressure: result held for 5 cycles, second vector waits for the handshake
    bus.out_ready = 1'b0;
    send(fill(16'd2));
    wait_out(1, lat);
    chk("b_lat", lat, 9);
    bus.in_data  = ramp();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("b_hold_data", $signed(bus.out_data), 42);
      chk("b_hold_valid", bus.out_valid, 1);
      chk("b_hold_in_ready", bus.in_ready, 0);
      tick();
    end
    bus.out_ready = 1'b1;
    chk("b_still_valid", bus.out_valid, 1);
    tick();
    chk("b2_in_ready", bus.in_ready, 1);
    chk("b2_not_busy", bus.busy, 0);
    chk("b2_valid_low", bus.out_valid, 0);
    tick();
    bus.in_valid = 1'b0;
    chk("b2_accepted", bus.busy, 1);
    wait_out(1, lat);
    chk("b2_lat", lat, 9);
    chk("b2_data", $signed(bus.out_data), 91);
    tick();

    // coefficient write while busy is dropped; in IDLE it applies; addr >= TAPS dropped
    send(fill(16'd1));
    tick();
    bus.coef_we   = 1'b1;
    bus.coef_addr = 3'd2;
    bus.coef_data = 16'd100;
    tick();
    bus.coef_we   = 1'b0;
    wait_out(3, lat);
    chk("c_lat", lat, 9);
    chk("c_data", $signed(bus.out_data), 21);
    tick();
    wr_coef(2, 16'd100);
    run("d", fill(16'd1), 118, 9);
    wr_coef(7, 16'd55);
    wr_coef(6, 16'd55);
    run("e", fill(16'd1), 118, 9);

    // signed extremes, no wrap
    wr_all(16'hFFFF);
    run("f", fill(16'h8000), 196608, 9);
    wr_all(16'h8000);
    run("g", fill(16'h8000), 64'sd6442450944, 9);

    // reset in cycle 4 aborts the vector and clears coefficients
    send(ramp());
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("h_rst_in_ready", bus.in_ready, 1);
    chk("h_rst_busy", bus.busy, 0);
    chk("h_rst_valid", bus.out_valid, 0);
    chk("h_rst_data", $signed(bus.out_data), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      tick();
      seen = seen | (bus.out_valid === 1'b1);
    end
    chk("h_no_output", seen, 0);
    run("h_zero_coef", fill(16'd2), 0, LAT_ZERO);
    for (int i = 0; i < TAPS - 1; i++) wr_coef(i, 16'd1);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 3'd5;
    bus.coef_data = 16'd1;
    bus.in_data   = fill(16'd2);
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus.coef_we   = 1'b0;
    wait_out(1, lat);
    chk("h_new_lat", lat, 9);
    chk("h_new_data", $signed(bus.out_data), 12);
    tick();

    // sparse coefficients {0,3,0,0,5,0} with samples 2
    wr_coef(0, 16'd0);
    wr_coef(1, 16'd3);
    wr_coef(2, 16'd0);
    wr_coef(3, 16'd0);
    wr_coef(4, 16'd5);
    wr_coef(5, 16'd0);
    run("z_sparse", fill(16'd2), 16, LAT_ZS);
    wr_all(16'd0);
    run("z_all_zero", fill(16'd7), 0, LAT_ZERO);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
